// File: rtl/sseg_mux_driver.sv
// Purpose: time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits on one shared cathode bus.
// Latency: every output is registered, so outputs show the scan/active state of the previous cycle. A load appears after the next frame boundary.
// Backpressure: none. load is always accepted. en=0 blanks the display and parks the scan at slot 0.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   en                  scan enable
//   value[4N-1:0]       hex nibbles, nibble i drives digit i (digit 0 least significant)
//   dp[N-1:0]           decimal point request per digit
//   digit_en[N-1:0]     per-digit enable
//   lz_blank            leading-zero blanking enable
//   load                strobe that captures value/dp/digit_en into the shadow register
//   seg[6:0], dp_n      active-low cathodes (seg[0]=a .. seg[6]=g)
//   an[N-1:0]           active-low anodes, at most one low at a time
//   frame_done          one-cycle pulse after the last slot of each scan
module sseg_mux_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // Segment patterns, g..a, active-low.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Shadow (written by load) and active (feeds the display) copies.
  logic [4*NUM_DIGITS-1:0] sh_val_q, sh_val_d, act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   sh_den_q, sh_den_d, act_den_q, act_den_d;
  logic                    pending_q, pending_d;

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;

  logic [6:0]              seg_q, seg_d;
  logic                    dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q, frame_done_d;

  logic cnt_wrap, idx_last, boundary;
  logic [3:0]    nib_sel;
  logic          dp_sel, den_sel;
  logic [IW-1:0] hi_idx;
  logic          lz_hit, lit;

  assign cnt_wrap = (cnt_q == CW'(REFRESH_DIV - 1));
  assign idx_last = (idx_q == IW'(NUM_DIGITS - 1));
  assign boundary = en && cnt_wrap && idx_last;

  // Scan counters.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!en) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (cnt_wrap) begin
      cnt_d = '0;
      idx_d = idx_last ? '0 : idx_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Shadow/active handoff. At the boundary the active copy takes the shadow
  // contents from before this cycle's load, so a load landing on the boundary
  // keeps pending set and waits one more frame.
  always_comb begin
    sh_val_d  = sh_val_q;
    sh_dp_d   = sh_dp_q;
    sh_den_d  = sh_den_q;
    act_val_d = act_val_q;
    act_dp_d  = act_dp_q;
    act_den_d = act_den_q;
    pending_d = pending_q;
    if (boundary && pending_q) begin
      act_val_d = sh_val_q;
      act_dp_d  = sh_dp_q;
      act_den_d = sh_den_q;
      pending_d = 1'b0;
    end
    if (load) begin
      sh_val_d  = value;
      sh_dp_d   = dp;
      sh_den_d  = digit_en;
      pending_d = 1'b1;
    end
  end

  // Select the current digit's data and find the highest non-zero nibble.
  // hi_idx stays 0 when every nibble is zero, which keeps digit 0 lit.
  always_comb begin
    nib_sel = 4'h0;
    dp_sel  = 1'b0;
    den_sel = 1'b0;
    hi_idx  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib_sel = act_val_q[4*i +: 4];
        dp_sel  = act_dp_q[i];
        den_sel = act_den_q[i];
      end
      if (act_val_q[4*i +: 4] != 4'h0) begin
        hi_idx = IW'(i);
      end
    end
  end

  assign lz_hit = lz_blank && (idx_q != '0) && (idx_q > hi_idx);
  assign lit    = en && (cnt_q >= CW'(BLANK_CYCLES)) && den_sel && !lz_hit;

  always_comb begin
    seg_d        = 7'h7F;
    dp_n_d       = 1'b1;
    an_d         = '1;
    frame_done_d = boundary;
    if (lit) begin
      seg_d  = hex_to_seg(nib_sel);
      dp_n_d = ~dp_sel;
      an_d   = ~(NUM_DIGITS'(1) << idx_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_val_q     <= '0;
      sh_dp_q      <= '0;
      sh_den_q     <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      act_den_q    <= '0;
      pending_q    <= 1'b0;
      cnt_q        <= '0;
      idx_q        <= '0;
      seg_q        <= 7'h7F;
      dp_n_q       <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      sh_val_q     <= sh_val_d;
      sh_dp_q      <= sh_dp_d;
      sh_den_q     <= sh_den_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      act_den_q    <= act_den_d;
      pending_q    <= pending_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      dp_n_q       <= dp_n_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp_n       = dp_n_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sseg_mux_driver.sv
// Bench for sseg_mux_driver with NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
// Expected per-cycle outputs are queued with the output cycle number; a monitor pops and compares on each falling edge.
module tb_sseg_mux_driver;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b1;
  logic [15:0]   value = '0;
  logic [3:0]    dp = '0;
  logic [3:0]    digit_en = '0;
  logic          lz_blank = 1'b0;
  logic          load = 1'b0;
  logic [6:0]    seg;
  logic          dp_n;
  logic [3:0]    an;
  logic          frame_done;

  sseg_mux_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .value(value), .dp(dp),
    .digit_en(digit_en), .lz_blank(lz_blank), .load(load),
    .seg(seg), .dp_n(dp_n), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Number of rising edges since reset release; output cycle t follows edge t.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    int         t;
    logic [6:0] seg;
    logic       dpn;
    logic [3:0] an;
    logic       fd;
  } exp_t;

  exp_t sbq[$];
  exp_t me;
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int t, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, req);
    end
  endtask

  // Hand-written encoding table, g..a.
  function automatic logic [6:0] enc(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  task automatic push_blank(input int t);
    exp_t e;
    e.t = t; e.seg = 7'h7F; e.dpn = 1'b1; e.an = 4'hF; e.fd = 1'b0;
    sbq.push_back(e);
  endtask

  // Expected outputs for the first n cycles of a scan whose first output cycle is base+1.
  task automatic push_frame(input int base, input int n, input logic [15:0] val,
                            input logic [3:0] dpv, input logic [3:0] den, input logic lz);
    exp_t e;
    int hi;
    int slot;
    int pos;
    logic [3:0] nib;
    logic lit;
    hi = 0;
    for (int i = 0; i < ND; i++) if (val[4*i +: 4] != 4'h0) hi = i;
    for (int j = 0; j < n; j++) begin
      slot = j / RD;
      pos  = j % RD;
      lit  = (pos >= BC) && den[slot] && !(lz && slot != 0 && slot > hi);
      nib  = val[4*slot +: 4];
      e.t  = base + 1 + j;
      e.fd = (j == ND*RD - 1);
      if (lit) begin
        e.seg = enc(nib);
        e.dpn = ~dpv[slot];
        e.an  = 4'hF;
        e.an[slot] = 1'b0;
      end else begin
        e.seg = 7'h7F; e.dpn = 1'b1; e.an = 4'hF;
      end
      sbq.push_back(e);
    end
  endtask

  // Monitor: compare every queued cycle as the DUT presents it.
  always @(negedge clk) begin
    if (rst_n) begin
      while (sbq.size() > 0 && sbq[0].t < cyc) begin
        me = sbq.pop_front();
        chk("stale_expectation", me.t, 32'(cyc), 32'(me.t));
      end
      if (sbq.size() > 0 && sbq[0].t == cyc) begin
        me = sbq.pop_front();
        chk("seg", me.t, 32'(seg), 32'(me.seg));
        chk("dp_n", me.t, 32'(dp_n), 32'(me.dpn));
        chk("an", me.t, 32'(an), 32'(me.an));
        chk("frame_done", me.t, 32'(frame_done), 32'(me.fd));
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Drive a load so that it is sampled on rising edge p.
  task automatic do_load(input int p, input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
    wait_cyc(p - 1);
    value = v; dp = d; digit_en = e; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_seg"}, cyc, 32'(seg), 32'h7F);
    chk({tag, "_dp_n"}, cyc, 32'(dp_n), 32'h1);
    chk({tag, "_an"}, cyc, 32'(an), 32'hF);
    chk({tag, "_frame_done"}, cyc, 32'(frame_done), 32'h0);
  endtask

  initial begin
    // Expected stream, frames of 32 cycles from output cycle 1.
    push_frame(0,   32, 16'h0000, 4'b0000, 4'b0000, 1'b0); // reset contents: all blank
    push_frame(32,  32, 16'h0000, 4'b0000, 4'b1111, 1'b0); // zeros on every digit
    push_frame(64,  32, 16'hA5F3, 4'b0100, 4'b1111, 1'b0); // mid-frame load, dp on digit 2
    push_frame(96,  32, 16'h0070, 4'b0000, 4'b1111, 1'b1); // leading zeros blanked
    push_frame(128, 32, 16'h0000, 4'b0000, 4'b1111, 1'b1); // only digit 0 lit
    push_frame(160, 32, 16'h1234, 4'b0000, 4'b1010, 1'b0); // digit enables
    push_frame(192, 32, 16'h9876, 4'b0000, 4'b1111, 1'b0); // shadow before boundary load
    push_frame(224, 32, 16'hBEEF, 4'b1001, 4'b1111, 1'b0); // boundary load, one frame later
    push_frame(256, 5,  16'hBEEF, 4'b1001, 4'b1111, 1'b0); // up to the en drop
    for (int t = 262; t <= 266; t++) push_blank(t);        // en low
    push_frame(266, 32, 16'hBEEF, 4'b1001, 4'b1111, 1'b0); // scan restarts at digit 0
    push_frame(298, 32, 16'h0001, 4'b0000, 4'b1111, 1'b0); // load taken while en was low
    push_frame(330, 5,  16'h0001, 4'b0000, 4'b1111, 1'b0); // up to the reset pulse

    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    #2 rst_n = 1'b1;

    do_load(5, 16'h0000, 4'b0000, 4'b1111);
    do_load(44, 16'hA5F3, 4'b0100, 4'b1111);
    wait_cyc(69);
    lz_blank = 1'b1;
    do_load(70, 16'h0070, 4'b0000, 4'b1111);
    do_load(100, 16'h0000, 4'b0000, 4'b1111);
    do_load(130, 16'h1234, 4'b0000, 4'b1010);
    wait_cyc(160);
    lz_blank = 1'b0;
    do_load(170, 16'h9876, 4'b0000, 4'b1111);
    do_load(192, 16'hBEEF, 4'b1001, 4'b1111);
    wait_cyc(261);
    en = 1'b0;
    do_load(264, 16'h0001, 4'b0000, 4'b1111);
    wait_cyc(266);
    en = 1'b1;

    // Pending data at reset time must be discarded.
    do_load(333, 16'h5555, 4'b1111, 4'b1111);
    wait_cyc(335);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_reset");
    push_frame(0,  32, 16'h0000, 4'b0000, 4'b0000, 1'b0);
    push_frame(32, 32, 16'h0000, 4'b0000, 4'b0000, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    for (int k = 0; k < 200 && sbq.size() > 0; k++) @(negedge clk);
    n_chk++;
    if (sbq.size() > 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d required=0", sbq.size());
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
